// File: rtl/jam_cost_server.sv
// Responder for the JAM cost-matrix read port. It loads an 8x8 cost matrix from a stream,
// serves registered W/J reads, then captures and checks the solver result or times out.
module jam_cost_server #(
    parameter int COST_W  = 7,
    parameter int N       = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    output logic              jam_rst,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    input  logic [9:0]        exp_min_cost,
    input  logic [3:0]        exp_match_count,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [9:0]        res_min_cost,
    output logic [3:0]        res_match_count,
    output logic [15:0]       cycle_count
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

    state_t            state;
    logic [5:0]        idx;
    logic [COST_W-1:0] mat [0:N*N-1];
    logic              xfer;

    assign xfer = (state == LOAD) && load_valid && load_ready;

    // Matrix storage has no reset; a fresh load after every reset defines it.
    always_ff @(posedge CLK) begin
        if (xfer) begin
            mat[idx] <= load_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state           <= LOAD;
            idx             <= 6'd0;
            jam_rst         <= 1'b1;
            load_ready      <= 1'b1;
            Cost            <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            res_min_cost    <= 10'd0;
            res_match_count <= 4'd0;
            cycle_count     <= 16'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        idx <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            state      <= SERVE;
                            load_ready <= 1'b0;
                            jam_rst    <= 1'b0;
                        end
                    end
                end
                SERVE: begin
                    Cost        <= mat[{W, J}];
                    cycle_count <= cycle_count + 16'd1;
                    // A result arriving on the last allowed cycle still counts as a capture.
                    if (Valid) begin
                        res_min_cost    <= MinCost;
                        res_match_count <= MatchCount;
                        pass            <= (MinCost == exp_min_cost) &&
                                           (MatchCount == exp_match_count);
                        done            <= 1'b1;
                        state           <= DONE;
                    end else if (cycle_count == LAST_CYCLE) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    Cost <= mat[{W, J}];
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: load, read latency, capture, mismatch, timeout, reset.
module tb_jam_cost_server;

    logic        CLK;
    logic        RST_N;
    logic        load_valid;
    logic [6:0]  load_data;
    logic        load_ready;
    logic        jam_rst;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        Valid;
    logic [9:0]  MinCost;
    logic [3:0]  MatchCount;
    logic [9:0]  exp_min_cost;
    logic [3:0]  exp_match_count;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [9:0]  res_min_cost;
    logic [3:0]  res_match_count;
    logic [15:0] cycle_count;

    int checks = 0;
    int passes = 0;
    int xfers;

    jam_cost_server #(.COST_W(7), .N(8), .TIMEOUT(100)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .exp_min_cost(exp_min_cost), .exp_match_count(exp_match_count),
        .done(done), .pass(pass), .timeout(timeout),
        .res_min_cost(res_min_cost), .res_match_count(res_match_count),
        .cycle_count(cycle_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    // Streams entry k = (7*k) mod 128; optional gap on every 3rd cycle.
    task automatic load_matrix(input bit gaps);
        int k = 0;
        int c = 0;
        xfers = 0;
        while (k < 64 && c < 300) begin
            load_valid = !(gaps && (c % 3 == 2));
            load_data  = 7'((7 * k) % 128);
            if (load_valid && load_ready) begin
                xfers++;
                k++;
            end
            tick();
            c++;
        end
        load_valid = 1'b0;
        chk("load_beats", 32'(xfers), 32'd64);
    endtask

    initial begin
        RST_N = 1'b1; load_valid = 1'b0; load_data = '0; W = '0; J = '0;
        Valid = 1'b0; MinCost = '0; MatchCount = '0;
        exp_min_cost = 10'd163; exp_match_count = 4'd2;
        #2;
        do_reset();

        chk("rst_jam_rst",     32'(jam_rst), 32'd1);
        chk("rst_load_ready",  32'(load_ready), 32'd1);
        chk("rst_done",        32'(done), 32'd0);
        chk("rst_pass",        32'(pass), 32'd0);
        chk("rst_timeout",     32'(timeout), 32'd0);
        chk("rst_cost",        32'(Cost), 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);

        // W/J are ignored while loading
        W = 3'd3; J = 3'd5;
        load_matrix(1'b1);
        chk("load_ready_after",  32'(load_ready), 32'd0);
        chk("jam_rst_after",     32'(jam_rst), 32'd0);
        chk("serve_cycle_start", 32'(cycle_count), 32'd0);
        chk("cost_held_in_load", 32'(Cost), 32'd0);

        // 65th beat must be refused and must not overwrite entry 0
        load_valid = 1'b1; load_data = 7'd99; W = 3'd0; J = 3'd0;
        chk("beat65_ready", 32'(load_ready), 32'd0);
        tick();
        load_valid = 1'b0;
        tick();
        chk("entry0_intact", 32'(Cost), 32'd0);

        W = 3'd3; J = 3'd5;
        tick();
        chk("cost_w3j5", 32'(Cost), 32'd75);
        W = 3'd7; J = 3'd0;
        tick();
        chk("cost_w7j0", 32'(Cost), 32'd8);
        chk("cycle_count_4", 32'(cycle_count), 32'd4);

        Valid = 1'b1; MinCost = 10'd163; MatchCount = 4'd2;
        chk("done_before_cap", 32'(done), 32'd0);
        tick();
        chk("cap_done",      32'(done), 32'd1);
        chk("cap_pass",      32'(pass), 32'd1);
        chk("cap_timeout",   32'(timeout), 32'd0);
        chk("cap_min_cost",  32'(res_min_cost), 32'd163);
        chk("cap_match",     32'(res_match_count), 32'd2);
        chk("cap_cycles",    32'(cycle_count), 32'd5);

        MinCost = 10'd5; MatchCount = 4'd1;
        W = 3'd3; J = 3'd5;
        tick();
        Valid = 1'b0;
        tick();
        chk("frozen_min_cost", 32'(res_min_cost), 32'd163);
        chk("frozen_match",    32'(res_match_count), 32'd2);
        chk("frozen_pass",     32'(pass), 32'd1);
        chk("frozen_cycles",   32'(cycle_count), 32'd5);
        chk("done_cost_track", 32'(Cost), 32'd75);

        // Capture exactly on the last allowed cycle, with a count mismatch
        do_reset();
        Valid = 1'b1;
        tick();
        tick();
        chk("valid_in_load_done",  32'(done), 32'd0);
        chk("valid_in_load_ready", 32'(load_ready), 32'd1);
        Valid = 1'b0;
        load_matrix(1'b0);
        for (int i = 0; i < 99; i++) tick();
        chk("sim_cycle_99", 32'(cycle_count), 32'd99);
        chk("sim_done_pre", 32'(done), 32'd0);
        Valid = 1'b1; MinCost = 10'd163; MatchCount = 4'd3;
        exp_min_cost = 10'd163; exp_match_count = 4'd2;
        tick();
        Valid = 1'b0;
        chk("sim_done",    32'(done), 32'd1);
        chk("sim_pass",    32'(pass), 32'd0);
        chk("sim_timeout", 32'(timeout), 32'd0);
        chk("sim_match",   32'(res_match_count), 32'd3);

        // Timeout with no result
        do_reset();
        load_matrix(1'b0);
        for (int i = 0; i < 99; i++) tick();
        chk("to_done_pre", 32'(done), 32'd0);
        tick();
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_done",    32'(done), 32'd1);
        chk("to_pass",    32'(pass), 32'd0);
        chk("to_cycles",  32'(cycle_count), 32'd100);
        tick();
        tick();
        chk("to_cycles_frozen", 32'(cycle_count), 32'd100);

        // Asynchronous reset in the middle of SERVE
        do_reset();
        load_matrix(1'b0);
        tick();
        tick();
        chk("mid_jam_rst_low", 32'(jam_rst), 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_jam_rst",    32'(jam_rst), 32'd1);
        chk("mid_load_ready", 32'(load_ready), 32'd1);
        chk("mid_done",       32'(done), 32'd0);
        chk("mid_timeout",    32'(timeout), 32'd0);
        chk("mid_cycles",     32'(cycle_count), 32'd0);
        tick();
        RST_N = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
